tlb_lookup: RTL and testbench
=============================

Name: tlb_lookup

Overview:
- Lookup stage of a set-associative TLB. Splits a 32-bit virtual address into VPN, set index and page offset.
- Compares the VPN against the NUM_WAYS entries of the selected set (supplied by the tag/data array), checks permissions, and produces hit/way/PPN/fault results.
- Results are available combinationally. A one-cycle registered response is also produced for the downstream pipeline stage.

Parameters:
- NUM_WAYS, 4, associativity; hit_way width is clog2(NUM_WAYS), which is 2 at the default.
- SET_INDEX_BITS, 4, set index width, taken from the low bits of the VPN.
- VPN_BITS, 20, virtual/physical page number width; page offset is 32-VPN_BITS = 12.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- vaddr  in  32  virtual address
- access_type  in  1  0=read, 1=write
- lookup_req  in  1  capture the current lookup into the response registers
- tlb_valid  in  NUM_WAYS  per-way valid bit; way i at bit i
- tlb_vpn  in  NUM_WAYS*20  per-way VPN tag; way i at [i*20 +: 20]
- tlb_ppn  in  NUM_WAYS*20  per-way PPN; way i at [i*20 +: 20]
- tlb_perms  in  NUM_WAYS*2  per-way permissions; way i at [i*2 +: 2]; bit0=R, bit1=W
- stats_clr  in  1  synchronous clear of the statistics counters
- vpn  out  20  vaddr[31:12]
- set_index  out  SET_INDEX_BITS  vaddr[12+SET_INDEX_BITS-1:12]
- page_offset  out  12  vaddr[11:0]
- hit  out  1  a valid way matches
- multi_hit  out  1  more than one valid way matches
- hit_way  out  2  matching way index
- hit_ppn  out  20  PPN of the matching way
- hit_perms  out  2  permissions of the matching way
- perm_fault  out  1  miss, or access not permitted
- resp_valid  out  1  registered response valid
- resp_hit  out  1  registered hit
- resp_fault  out  1  registered perm_fault
- resp_way  out  2  registered hit_way
- resp_paddr  out  32  registered {hit_ppn, page_offset}
- hit_count, miss_count, fault_count  out  32 each  statistics counters

Behaviour:
- Combinational outputs (zero latency, pure function of the inputs):
  - Way i matches when tlb_valid[i]=1 and tlb_vpn[i] equals the full 20-bit vpn.
  - hit = OR of all way matches.
  - multi_hit = 1 when two or more ways match.
  - On multiple matches the lowest-numbered way wins.
  - On a miss, hit_way, hit_ppn and hit_perms are all 0.
- perm_fault is 1 in any of these cases:
  - miss (hit=0);
  - read (access_type=0) with hit_perms[0]=0;
  - write (access_type=1) with hit_perms[1]=0.
- Write permission depends only on bit1; the R bit is not required for a write.
- perm_fault is 0 otherwise.
- Example: perms 2'b01 with a write gives perm_fault=1; perms 2'b11 with a write gives perm_fault=0.
- Registered response, on the rising edge of clk:
  - resp_valid takes the value of lookup_req.
  - When lookup_req=1, resp_hit, resp_fault, resp_way and resp_paddr capture the combinational values.
  - When lookup_req=0, these four registers hold their previous values.
  - Latency is 1 cycle; back-to-back requests are accepted every cycle.
- Reset (rst_n=0, asynchronous): all registered outputs and counters go to 0. Combinational outputs are unaffected. Reset asserted mid-operation drops any pending response (resp_valid=0).

Optional Feature:
- Macro: TLB_LOOKUP_STATS_EN.
- When defined, on each clock edge with lookup_req=1:
  - hit_count increments when hit=1 and perm_fault=0;
  - miss_count increments when hit=0;
  - fault_count increments when hit=1 and perm_fault=1.
- Counters saturate at 32'hFFFFFFFF.
- stats_clr=1 zeroes all three counters and takes priority over a simultaneous increment.
- When not defined, the counter ports still exist, are tied to 0, and stats_clr is ignored.

Test Plan:
- vaddr=32'hABCDE123 -> vpn=20'hABCDE, set_index=4'hE, page_offset=12'h123.
- All ways invalid, vaddr=32'h12345678, read -> hit=0, perm_fault=1, hit_ppn=0.
- Hit cases:
  - way0 {valid, 12345, 54321, 11}, read of 32'h12345678 -> hit=1, hit_way=0, hit_ppn=20'h54321, fault=0.
  - Same entry in way3 with PPN 99999 -> hit_way=3, hit_ppn=20'h99999.
- Permissions:
  - way1 perms 00, read of 32'h88888123 -> hit=1, fault=1.
  - way2 perms 01, write of 32'h66666789 -> hit=1, fault=1.
  - way0 perms 11, write of 32'hFFFFF000 -> fault=0.
- Ways 0 and 1 hold VPNs 12345 and 12346; vaddr=32'h12347000 -> miss, fault=1. Both ways set to VPN 12345 -> multi_hit=1, hit_way=0.
- Response path and counters:
  - Pulse lookup_req on a hit at vaddr=...678 -> next cycle resp_valid=1, resp_paddr=32'h54321678.
  - With TLB_LOOKUP_STATS_EN: hit_count=1 after that request. Asserting rst_n=0 mid-stream clears resp_valid and all counters immediately.

Source files
------------

// File: rtl/tlb_lookup_if.sv
// Lookup bus between the TLB tag/data array, the requester and the lookup stage.
// master drives the request and array contents; slave is the lookup stage.
interface tlb_lookup_if #(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned SET_INDEX_BITS = 4,
  parameter int unsigned VPN_BITS       = 20
);
  localparam int unsigned OFF_W = 32 - VPN_BITS;
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [31:0]                  vaddr;
  logic                         access_type;
  logic                         lookup_req;
  logic [NUM_WAYS-1:0]          tlb_valid;
  logic [NUM_WAYS*VPN_BITS-1:0] tlb_vpn;
  logic [NUM_WAYS*VPN_BITS-1:0] tlb_ppn;
  logic [NUM_WAYS*2-1:0]        tlb_perms;
  logic                         stats_clr;

  logic [VPN_BITS-1:0]          vpn;
  logic [SET_INDEX_BITS-1:0]    set_index;
  logic [OFF_W-1:0]             page_offset;
  logic                         hit;
  logic                         multi_hit;
  logic [WAY_W-1:0]             hit_way;
  logic [VPN_BITS-1:0]          hit_ppn;
  logic [1:0]                   hit_perms;
  logic                         perm_fault;
  logic                         resp_valid;
  logic                         resp_hit;
  logic                         resp_fault;
  logic [WAY_W-1:0]             resp_way;
  logic [31:0]                  resp_paddr;
  logic [31:0]                  hit_count;
  logic [31:0]                  miss_count;
  logic [31:0]                  fault_count;

  modport master (
    output vaddr, access_type, lookup_req, tlb_valid, tlb_vpn, tlb_ppn, tlb_perms, stats_clr,
    input  vpn, set_index, page_offset, hit, multi_hit, hit_way, hit_ppn, hit_perms,
           perm_fault, resp_valid, resp_hit, resp_fault, resp_way, resp_paddr,
           hit_count, miss_count, fault_count
  );

  modport slave (
    input  vaddr, access_type, lookup_req, tlb_valid, tlb_vpn, tlb_ppn, tlb_perms, stats_clr,
    output vpn, set_index, page_offset, hit, multi_hit, hit_way, hit_ppn, hit_perms,
           perm_fault, resp_valid, resp_hit, resp_fault, resp_way, resp_paddr,
           hit_count, miss_count, fault_count
  );
endinterface

// File: rtl/tlb_lookup.sv
// Set-associative TLB lookup stage: tag compare, permission check, registered response.
// Optional hit/miss/fault statistics counters enabled by TLB_LOOKUP_STATS_EN.
module tlb_lookup #(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned SET_INDEX_BITS = 4,
  parameter int unsigned VPN_BITS       = 20
) (
  input logic        clk,
  input logic        rst_n,
  tlb_lookup_if.slave bus
);
  localparam int unsigned OFF_W = 32 - VPN_BITS;
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [VPN_BITS-1:0] vpn_c;
  logic [NUM_WAYS-1:0] match_c;
  logic                hit_c;
  logic                multi_c;
  logic [WAY_W-1:0]    way_c;
  logic [VPN_BITS-1:0] ppn_c;
  logic [1:0]          perms_c;
  logic                fault_c;
  logic [31:0]         paddr_c;

  assign vpn_c = bus.vaddr[OFF_W +: VPN_BITS];

  // Per-way tag compare against the full VPN
  always_comb begin
    match_c = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      match_c[i] = bus.tlb_valid[i] && (bus.tlb_vpn[i*VPN_BITS +: VPN_BITS] == vpn_c);
    end
  end

  // Descending scan so the lowest-numbered matching way is the last assignment
  always_comb begin
    way_c   = '0;
    ppn_c   = '0;
    perms_c = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (match_c[i]) begin
        way_c   = WAY_W'(i);
        ppn_c   = bus.tlb_ppn[i*VPN_BITS +: VPN_BITS];
        perms_c = bus.tlb_perms[i*2 +: 2];
      end
    end
  end

  assign hit_c   = |match_c;
  assign multi_c = |(match_c & (match_c - NUM_WAYS'(1)));
  assign fault_c = !hit_c || (bus.access_type ? !perms_c[1] : !perms_c[0]);
  assign paddr_c = {ppn_c, bus.vaddr[OFF_W-1:0]};

  assign bus.vpn         = vpn_c;
  assign bus.set_index   = bus.vaddr[OFF_W +: SET_INDEX_BITS];
  assign bus.page_offset = bus.vaddr[OFF_W-1:0];
  assign bus.hit         = hit_c;
  assign bus.multi_hit   = multi_c;
  assign bus.hit_way     = way_c;
  assign bus.hit_ppn     = ppn_c;
  assign bus.hit_perms   = perms_c;
  assign bus.perm_fault  = fault_c;

  logic             resp_valid_q;
  logic             resp_hit_q;
  logic             resp_fault_q;
  logic [WAY_W-1:0] resp_way_q;
  logic [31:0]      resp_paddr_q;

  // Response payload only updates on a request; valid tracks the request every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_way_q   <= '0;
      resp_paddr_q <= '0;
    end else begin
      resp_valid_q <= bus.lookup_req;
      if (bus.lookup_req) begin
        resp_hit_q   <= hit_c;
        resp_fault_q <= fault_c;
        resp_way_q   <= way_c;
        resp_paddr_q <= paddr_c;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.resp_paddr = resp_paddr_q;

`ifdef TLB_LOOKUP_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] fault_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Clear wins over a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else if (bus.stats_clr) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else if (bus.lookup_req) begin
      if (hit_c && !fault_c) hit_cnt_q   <= sat_inc(hit_cnt_q);
      if (!hit_c)            miss_cnt_q  <= sat_inc(miss_cnt_q);
      if (hit_c && fault_c)  fault_cnt_q <= sat_inc(fault_cnt_q);
    end
  end

  assign bus.hit_count   = hit_cnt_q;
  assign bus.miss_count  = miss_cnt_q;
  assign bus.fault_count = fault_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = bus.stats_clr;
  assign bus.hit_count    = '0;
  assign bus.miss_count   = '0;
  assign bus.fault_count  = '0;
`endif
endmodule

// File: tb/tb_tlb_lookup.sv
// Scoreboard bench for tlb_lookup: directed lookups with hand-computed results.
// Build with TLB_LOOKUP_STATS_EN defined to also exercise the statistics counters.
module tb_tlb_lookup;
  logic clk;
  logic rst_n;

  tlb_lookup_if #(.NUM_WAYS(4), .SET_INDEX_BITS(4), .VPN_BITS(20)) bus ();

  tlb_lookup #(.NUM_WAYS(4), .SET_INDEX_BITS(4), .VPN_BITS(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic        fault;
    logic [1:0]  way;
    logic [31:0] paddr;
  } resp_t;

  resp_t exp_q[$];
  resp_t held;
  int    n_checks = 0;
  int    n_fail   = 0;

  logic [3:0]  tv_valid;
  logic [19:0] tv_vpn   [4];
  logic [19:0] tv_ppn   [4];
  logic [1:0]  tv_perms [4];

  logic [31:0] m_hit, m_miss, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_ways();
    tv_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tv_vpn[i] = '0; tv_ppn[i] = '0; tv_perms[i] = '0;
    end
  endtask

  task automatic set_way(input int w, input logic [19:0] v, input logic [19:0] p,
                         input logic [1:0] pr);
    tv_valid[w] = 1'b1; tv_vpn[w] = v; tv_ppn[w] = p; tv_perms[w] = pr;
  endtask

  // Drive one vector at the falling edge, check the combinational result, queue the response
  task automatic lookup(input logic [31:0] va, input logic acc, input logic req,
                        input logic clr, input logic e_hit, input logic e_multi,
                        input logic [1:0] e_way, input logic [19:0] e_ppn,
                        input logic [1:0] e_perms, input logic e_fault);
    resp_t e;
    @(negedge clk);
    bus.vaddr       = va;
    bus.access_type = acc;
    bus.lookup_req  = req;
    bus.stats_clr   = clr;
    bus.tlb_valid   = tv_valid;
    for (int i = 0; i < 4; i++) begin
      bus.tlb_vpn[i*20 +: 20] = tv_vpn[i];
      bus.tlb_ppn[i*20 +: 20] = tv_ppn[i];
      bus.tlb_perms[i*2 +: 2] = tv_perms[i];
    end
    #1;
    chk("vpn",         bus.vpn,         va[31:12]);
    chk("set_index",   bus.set_index,   va[15:12]);
    chk("page_offset", bus.page_offset, va[11:0]);
    chk("hit",         bus.hit,         e_hit);
    chk("multi_hit",   bus.multi_hit,   e_multi);
    chk("hit_way",     bus.hit_way,     e_way);
    chk("hit_ppn",     bus.hit_ppn,     e_ppn);
    chk("hit_perms",   bus.hit_perms,   e_perms);
    chk("perm_fault",  bus.perm_fault,  e_fault);
    if (req) begin
      e.hit   = e_hit;
      e.fault = e_fault;
      e.way   = e_way;
      e.paddr = {e_ppn, va[11:0]};
      exp_q.push_back(e);
`ifdef TLB_LOOKUP_STATS_EN
      if (clr) begin
        m_hit = '0; m_miss = '0; m_fault = '0;
      end else begin
        if (e_hit && !e_fault) m_hit++;
        if (!e_hit)            m_miss++;
        if (e_hit && e_fault)  m_fault++;
      end
`endif
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.lookup_req = 1'b0;
    bus.stats_clr  = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, " hit_count"},   bus.hit_count,   m_hit);
    chk({tag, " miss_count"},  bus.miss_count,  m_miss);
    chk({tag, " fault_count"}, bus.fault_count, m_fault);
  endtask

  // Monitor: compares the registered response against the scoreboard or the held value
  initial begin
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
      end else if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected resp_valid", 32'd1, 32'd0);
        end else begin
          held = exp_q.pop_front();
          chk("resp_hit",   bus.resp_hit,   held.hit);
          chk("resp_fault", bus.resp_fault, held.fault);
          chk("resp_way",   bus.resp_way,   held.way);
          chk("resp_paddr", bus.resp_paddr, held.paddr);
        end
      end else begin
        chk("held resp_paddr", bus.resp_paddr, held.paddr);
        chk("held resp_way",   bus.resp_way,   held.way);
      end
    end
  end

  initial begin
    m_hit = '0; m_miss = '0; m_fault = '0;
    rst_n = 1'b0;
    bus.vaddr = '0; bus.access_type = 1'b0; bus.lookup_req = 1'b0; bus.stats_clr = 1'b0;
    bus.tlb_valid = '0; bus.tlb_vpn = '0; bus.tlb_ppn = '0; bus.tlb_perms = '0;
    clear_ways();
    #1;
    chk("reset resp_valid", bus.resp_valid, 1'b0);
    chk("reset resp_paddr", bus.resp_paddr, 32'h0);
    check_stats("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Address split with an empty set
    lookup(32'hABCDE123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 20'h0, 2'b00, 1'b1);
    chk("decode vpn",    bus.vpn,         20'hABCDE);
    chk("decode set",    bus.set_index,   4'hE);
    chk("decode offset", bus.page_offset, 12'h123);
    lookup(32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 20'h0, 2'b00, 1'b1);

    set_way(0, 20'h12345, 20'h54321, 2'b11);
    lookup(32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 20'h54321, 2'b11, 1'b0);

    clear_ways();
    set_way(3, 20'h12345, 20'h99999, 2'b11);
    lookup(32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 20'h99999, 2'b11, 1'b0);

    // Permission checks
    clear_ways();
    set_way(1, 20'h88888, 20'hAAAAA, 2'b00);
    lookup(32'h88888123, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 20'hAAAAA, 2'b00, 1'b1);
    clear_ways();
    set_way(2, 20'h66666, 20'hBBBBB, 2'b01);
    lookup(32'h66666789, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 20'hBBBBB, 2'b01, 1'b1);
    lookup(32'h66666789, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 20'hBBBBB, 2'b01, 1'b0);
    clear_ways();
    set_way(0, 20'hFFFFF, 20'hCCCCC, 2'b11);
    lookup(32'hFFFFF000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 20'hCCCCC, 2'b11, 1'b0);
    set_way(0, 20'hFFFFF, 20'hCCCCC, 2'b10);
    lookup(32'hFFFFF000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 20'hCCCCC, 2'b10, 1'b0);
    lookup(32'hFFFFF000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 20'hCCCCC, 2'b10, 1'b1);

    // Near-miss VPNs, then multiple matches and an invalid lower way
    clear_ways();
    set_way(0, 20'h12345, 20'h11111, 2'b11);
    set_way(1, 20'h12346, 20'h22222, 2'b11);
    lookup(32'h12347000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 20'h0, 2'b00, 1'b1);
    set_way(1, 20'h12345, 20'h22222, 2'b11);
    lookup(32'h12345ABC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 20'h11111, 2'b11, 1'b0);
    clear_ways();
    set_way(0, 20'h12345, 20'h11111, 2'b11);
    tv_valid[0] = 1'b0;
    set_way(2, 20'h12345, 20'h33333, 2'b01);
    lookup(32'h12345ABC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 20'h33333, 2'b01, 1'b0);

    // No request: response registers must hold the last captured values
    clear_ways();
    set_way(0, 20'h12345, 20'h54321, 2'b11);
    lookup(32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 20'h0, 2'b00, 1'b1);
    lookup(32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 20'h54321, 2'b11, 1'b0);
    idle();
    check_stats("run");

    // Clear takes priority over a simultaneous counted request
    lookup(32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 20'h54321, 2'b11, 1'b0);
    idle();
    check_stats("after clr");
    lookup(32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 20'h54321, 2'b11, 1'b0);
    idle();
    check_stats("post clr");

    // Reset while a response is presented drops it and clears the counters
    lookup(32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 20'h54321, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    chk("pre-reset resp_valid", bus.resp_valid, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    m_hit = '0; m_miss = '0; m_fault = '0;
    #1;
    chk("mid reset resp_valid", bus.resp_valid, 1'b0);
    chk("mid reset resp_paddr", bus.resp_paddr, 32'h0);
    check_stats("mid reset");
    @(negedge clk);
    bus.lookup_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    chk("final resp_valid", bus.resp_valid, 1'b0);
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
